// File: rtl/cic_pkg.sv
// Shared CIC definitions: internal sample width and sizing helpers
// common to the interpolator and decimator.
package cic_pkg;

    localparam int CIC_DATA_W = 32;

    typedef logic signed [CIC_DATA_W-1:0] cic_data_t;

    function automatic int clog2(input longint v);
        int     r;
        longint x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    // Register width needed for bit-exact results: input width plus log2 of the DC gain.
    function automatic int growth_width(input int in_w, input int n, input int r, input int m);
        longint g;
        g = 1;
        for (int i = 0; i < n; i++) g = g * longint'(r * m);
        return in_w + clog2(g / longint'(r));
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x[-M], advanced only when a sample token is present.
module cic_comb_stage import cic_pkg::*; #(
    parameter int M            = 1,
    parameter int OutDataWidth = CIC_DATA_W
) (
    input  logic                    clk50,
    input  logic                    rst,
    input  logic                    tok_i,
    input  logic [OutDataWidth-1:0] x_i,
    output logic                    tok_o,
    output logic [OutDataWidth-1:0] y_o
);

    logic [M-1:0][OutDataWidth-1:0] dly_q;
    logic                           tok_q;
    logic [OutDataWidth-1:0]        y_q;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            dly_q <= '0;
            tok_q <= 1'b0;
            y_q   <= '0;
        end else begin
            tok_q <= tok_i;
            // The delay line is counted in samples, not clocks, so it only shifts on a token.
            if (tok_i) begin
                y_q      <= x_i - dly_q[M-1];
                dly_q[0] <= x_i;
                for (int i = 1; i < M; i++) dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign tok_o = tok_q;
    assign y_o   = y_q;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: one input per R clocks via rdy/nd handshake, N combs at the
// sample rate, zero-stuffing upsampler, N integrators at the clock rate.
module cic_interpolator import cic_pkg::*; #(
    parameter int N              = 4,
    parameter int M              = 1,
    parameter int InDataWidth    = 14,
    parameter int OutDataWidth   = CIC_DATA_W,
    parameter int InterpCntWidth = 7
) (
    input  logic                      clk50,
    input  logic                      rst,
    input  logic [InterpCntWidth-1:0] interp_factor_i,
    input  logic [InDataWidth-1:0]    data_i,
    input  logic                      data_nd_i,
    output logic                      data_rdy_o,
    output logic [OutDataWidth-1:0]   data_o,
    output logic                      data_valid_o,
    output logic                      underflow_o
);

    localparam int VW = 2 * N;
    localparam logic [InterpCntWidth-1:0] ONE = InterpCntWidth'(1);

    logic [InterpCntWidth-1:0] phase_q, phase_d, r_eff_q, r_eff_in;
    logic                      started_q, rdy_q, uflow_q, dvalid_q;
    logic                      in_tok_q;
    logic [OutDataWidth-1:0]   in_x_q, x_ext, up_x;
    logic [VW-1:0]             vld_pipe_q;
    logic [N:0]                tok;
    logic [N:0][OutDataWidth-1:0]   cx;
    logic [N-1:0][OutDataWidth-1:0] integ_q;

    always_comb begin
        r_eff_in = (interp_factor_i == '0) ? ONE : interp_factor_i;
        phase_d  = (phase_q >= r_eff_q - ONE) ? '0 : phase_q + ONE;
        x_ext    = {{(OutDataWidth-InDataWidth){data_i[InDataWidth-1]}}, data_i};
    end

    // Phase counter and request slot; the factor is only picked up when a period starts.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
            phase_q   <= '0;
            r_eff_q   <= ONE;
            rdy_q     <= 1'b0;
        end else if (!started_q) begin
            started_q <= 1'b1;
            phase_q   <= '0;
            r_eff_q   <= r_eff_in;
            rdy_q     <= 1'b1;
        end else begin
            phase_q <= phase_d;
            rdy_q   <= (phase_d == '0);
            if (phase_d == '0) r_eff_q <= r_eff_in;
        end
    end

    // Sample capture: a missed slot still pushes a zero token so the comb rate stays fixed.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            in_tok_q   <= 1'b0;
            in_x_q     <= '0;
            uflow_q    <= 1'b0;
            vld_pipe_q <= '0;
            dvalid_q   <= 1'b0;
        end else begin
            in_tok_q   <= rdy_q;
            in_x_q     <= (rdy_q && data_nd_i) ? x_ext : '0;
            if (rdy_q && !data_nd_i) uflow_q <= 1'b1;
            vld_pipe_q <= {vld_pipe_q[VW-2:0], rdy_q & data_nd_i};
            dvalid_q   <= dvalid_q | vld_pipe_q[VW-1];
        end
    end

    assign tok[0] = in_tok_q;
    assign cx[0]  = in_x_q;

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(
            .M            (M),
            .OutDataWidth (OutDataWidth)
        ) u_comb (
            .clk50 (clk50),
            .rst   (rst),
            .tok_i (tok[k]),
            .x_i   (cx[k]),
            .tok_o (tok[k+1]),
            .y_o   (cx[k+1])
        );
    end

    assign up_x = tok[N] ? cx[N] : '0;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            integ_q <= '0;
        end else begin
            integ_q[0] <= integ_q[0] + up_x;
            for (int k = 1; k < N; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
        end
    end

    assign data_rdy_o   = rdy_q;
    assign data_o       = integ_q[N-1];
    assign data_valid_o = dvalid_q;
    assign underflow_o  = uflow_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed and reference-model bench for cic_interpolator (N=4/M=1 and N=3/M=2 instances).
module tb_cic_interpolator;

    logic clk50 = 1'b0;
    logic rst   = 1'b1;
    always #10 clk50 = ~clk50;

    logic [6:0]  fac_a, fac_b;
    logic [13:0] din_a, din_b;
    logic        nd_a, nd_b;
    logic        rdy_a, dv_a, uf_a, rdy_b, dv_b, uf_b;
    logic [31:0] do_a, do_b;

    cic_interpolator #(.N(4), .M(1)) dut_a (
        .clk50(clk50), .rst(rst), .interp_factor_i(fac_a), .data_i(din_a),
        .data_nd_i(nd_a), .data_rdy_o(rdy_a), .data_o(do_a),
        .data_valid_o(dv_a), .underflow_o(uf_a));

    cic_interpolator #(.N(3), .M(2)) dut_b (
        .clk50(clk50), .rst(rst), .interp_factor_i(fac_b), .data_i(din_b),
        .data_nd_i(nd_b), .data_rdy_o(rdy_b), .data_o(do_b),
        .data_valid_o(dv_b), .underflow_o(uf_b));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic               nd;
        logic signed [13:0] din;
        logic               rdy;
        logic               vld;
        longint             dat;
    } vec_t;

    vec_t   tbl [1:30];
    longint imp [0:16] = '{1, 4, 10, 20, 35, 52, 68, 80, 85, 80, 68, 52, 35, 20, 10, 4, 1};
    longint h   [0:63];
    longint ht  [0:63];
    longint u   [0:3599];

    task automatic do_reset();
        @(negedge clk50);
        rst = 1'b1;
        nd_a = 1'b0; din_a = '0; nd_b = 1'b0; din_b = '0;
        #1;
        chk("rst_data", longint'($signed(do_a)), 0);
        chk("rst_valid", dv_a, 0);
        chk("rst_rdy", rdy_a, 0);
        chk("rst_uflow", uf_a, 0);
        repeat (2) @(negedge clk50);
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk50);
            chk({tag, "_rdy"}, rdy_a, tbl[k].rdy);
            chk({tag, "_valid"}, dv_a, tbl[k].vld);
            chk({tag, "_data"}, longint'($signed(do_a)), tbl[k].dat);
            chk({tag, "_uflow"}, uf_a, 0);
            nd_a  = tbl[k].nd;
            din_a = tbl[k].din;
        end
    endtask

    initial begin
        int hl, ns;

        // Impulse at the first slot, zeros at later slots, junk with nd=1 off-slot.
        for (int k = 1; k <= 30; k++) begin
            tbl[k].rdy = ((k % 5) == 1);
            tbl[k].nd  = 1'b1;
            tbl[k].din = tbl[k].rdy ? ((k == 1) ? 14'sd1 : 14'sd0) : 14'sd77;
            tbl[k].vld = (k >= 10);
            tbl[k].dat = (k >= 10 && k <= 26) ? imp[k-10] : 0;
        end

        fac_a = 7'd5; fac_b = 7'd7;
        nd_a = 1'b0; din_a = '0; nd_b = 1'b0; din_b = '0;

        do_reset();
        run_table("imp");

        // DC response
        do_reset();
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk50);
            if (k >= 41 && k <= 45) chk("dc_pos", longint'($signed(do_a)), 125);
            if (k >= 116)           chk("dc_neg", longint'($signed(do_a)), -1023875);
            nd_a  = 1'b1;
            din_a = (k <= 60) ? 14'sd1 : -14'sd8191;
        end

        // Missed slot at cycle 6, then reset in the impulse tail and a bit-exact rerun
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk50);
            chk("uf_flag", uf_a, (k >= 7) ? 1 : 0);
            if (k == 10 || k == 14) chk("uf_data", longint'($signed(do_a)), imp[k-10]);
            nd_a  = (k != 6);
            din_a = (k == 1) ? 14'sd1 : 14'sd0;
        end
        do_reset();
        run_table("rerun");

        // Factor change 5 -> 3 mid-period, then 0 (treated as 1)
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk50);
            chk("fac_rdy", rdy_a,
                (k == 1 || k == 6 || k == 9 || k == 12 || k == 15 || k >= 18) ? 1 : 0);
            nd_a = 1'b1;
            if (k == 3)  fac_a = 7'd3;
            if (k == 15) fac_a = 7'd0;
        end
        fac_a = 7'd5;

        // Reference impulse response for N=3, M=2, R=7: box of length 14 convolved 3 times
        for (int i = 0; i < 64; i++) h[i] = 0;
        h[0] = 1;
        hl = 1;
        repeat (3) begin
            for (int i = 0; i < 64; i++) ht[i] = 0;
            for (int i = 0; i < hl; i++)
                for (int j = 0; j < 14; j++) ht[i+j] += h[i];
            for (int i = 0; i < 64; i++) h[i] = ht[i];
            hl += 13;
        end
        for (int i = 0; i < 3600; i++) u[i] = 0;

        do_reset();
        ns = 0;
        for (int c = 1; c <= 3560; c++) begin
            longint y;
            @(negedge clk50);
            y = 0;
            for (int i = 0; i < hl; i++)
                if (c - 6 - i >= 0) y += h[i] * u[c-6-i];
            chk("rnd_rdy", rdy_b, ((c % 7) == 1) ? 1 : 0);
            chk("rnd_valid", dv_b, (c >= 8) ? 1 : 0);
            if (c >= 8) chk("rnd_data", longint'($signed(do_b)), y);
            if ((c % 7) == 1) begin
                nd_b  = 1'b1;
                din_b = (ns < 500) ? 14'($urandom_range(0, 16383)) : 14'd0;
                u[c+1] = longint'($signed(din_b));
                ns++;
            end else begin
                nd_b  = 1'($urandom_range(0, 1));
                din_b = 14'($urandom_range(0, 16383));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Cascaded integrator-comb interpolation filter: the transmit-side counterpart of the CIC decimator. It accepts one low-rate sample every R clocks through a ready/new-data handshake and produces one interpolated sample every clk50 cycle. It sits between a baseband sample source and a DAC or NCO mixer in the 50 MHz domain.

## Interface
- N, 4, number of comb and integrator stages (1..8)
- M, 1, comb differential delay (1 or 2)
- InDataWidth, 14, signed input width
- OutDataWidth, 32, signed output width and width of every internal register
- InterpCntWidth, 7, width of interpolation factor and phase counter
- clk50  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- interp_factor_i  in  InterpCntWidth  interpolation factor R; 0 treated as 1
- data_i  in  InDataWidth  signed input sample
- data_nd_i  in  1  new data; sample taken when data_nd_i & data_rdy_o
- data_rdy_o  out  1  one-cycle request slot, once per R cycles
- data_o  out  OutDataWidth  signed interpolated output
- data_valid_o  out  1  data_o meaningful; stays high once set
- underflow_o  out  1  sticky: a slot passed without data_nd_i

## Operation
- Phase counter: counts 0..R_eff-1, wraps to 0. R_eff = interp_factor_i (1 if 0), latched into a register at every wrap to 0 and at the first cycle after reset. A mid-stream change of interp_factor_i takes effect at the next wrap.
- data_rdy_o is registered and high exactly in the cycle where phase==0. With R_eff=1 it is high every cycle.
- Slot handling:
  - Slot cycle with data_nd_i=1: data_i is sign-extended to OutDataWidth and enters comb stage 1 with a valid token.
  - Slot cycle with data_nd_i=0: a zero sample enters with a token, and underflow_o sets. underflow_o clears only on rst.
  - data_nd_i outside a slot is ignored.
- Comb section: N registered stages, one per clock, driven by a token pipeline. Stage k computes y = x - x[-M] and updates its M-deep delay line only when its token is present.
- Upsampler: the integrator input is the comb-N output in the cycle its token arrives, and zero in every other cycle (zero stuffing).
- Integrator section: N registered stages, y <= y + x, updating every cycle. data_o is the integrator-N register.
- Arithmetic: all stages use OutDataWidth two's-complement wrap-around. No saturation and no truncation.
  - Results are exact when OutDataWidth >= InDataWidth + ceil(log2((R*M)^N / R)). Meeting this is the integrator's responsibility.
  - DC gain is (R*M)^N / R.
- data_valid_o sets when the token of the first sample accepted with data_nd_i=1 reaches the output, and then stays high. Zero-inserted underflow samples do not set it.

## Timing
- Reset values: data_rdy_o=0, data_valid_o=0, underflow_o=0, data_o=0. Phase counter, all comb delay lines, tokens and integrators are 0.
- First slot: data_rdy_o=1 on the first rising edge after rst falls.
- Latency: a sample accepted at edge t first contributes to data_o at edge t+2N (N comb stages plus N integrator stages).
- Throughput: one output per clock after valid; one input per R_eff clocks.
- rst asserted mid-operation: every register returns to its reset value asynchronously. The pipeline restarts from empty with no residual state.
- Simultaneous slot and factor change: the slot uses the old R_eff; the new value governs the following period.

## Structure
- Shared package cic_pkg:
  - clog2 function
  - growth-width function for the exactness bound above
  - a shared cic_data_t-style width constant for the internal width, common with the decimator
- Sub-module cic_comb_stage:
  - parameters M and OutDataWidth
  - ports: tok_i, x_i, tok_o, y_o
  - instantiated N times in a generate loop
- Integrators are inline registers in the top module.

## Test plan
- Impulse, N=4, M=1, R=5: single sample 1, then zeros at every slot -> 17 nonzero outputs 1,4,10,20,35,52,68,80,85,80,68,52,35,20,10,4,1 starting 8 cycles after acceptance, then 0; sum 625.
- DC, N=4, R=5: data_i=1 at every slot -> data_o settles to constant 125; data_i=-8191 -> settles to -1023875.
- Handshake: R=5 -> data_rdy_o pulses on cycles 1,6,11,… after reset. Withholding data_nd_i at one slot -> underflow_o=1 from the next edge until rst, and the output equals the impulse response of a zero at that slot.
- Factor change: switch interp_factor_i 5->3 mid-period -> current period completes at 5, following slot gaps are 3; R=0 -> data_rdy_o high every cycle.
- Reset mid-stream: assert rst during the impulse tail -> data_o=0, data_valid_o=0, data_rdy_o=0 immediately; after release the impulse test repeats bit-exactly.
- Random stimulus (N=3, M=2, R=7): 500 random 14-bit samples -> data_o matches a bit-accurate reference model every cycle after valid.
